// File: rtl/slot_game_ctrl.sv
// Three-reel slot machine controller: credit/bet bookkeeping, staggered reel stop,
// payline evaluation and cash-out. LFSR-driven spin extension when RAND_EN is set.
module slot_game_ctrl #(
    parameter int unsigned SPIN_MIN    = 32,
    parameter int unsigned STAGGER     = 16,
    parameter logic [9:0]  CREDIT_INIT = 10'd100,
    parameter bit          RAND_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_bet,
    input  logic       btn_spin,
    input  logic       btn_cash,
    output logic [1:0] reel_pos0,
    output logic [1:0] reel_pos1,
    output logic [1:0] reel_pos2,
    output logic [2:0] reel_stopped,
    output logic       stop,
    output logic [9:0] credits,
    output logic [1:0] bet,
    output logic [9:0] payout,
    output logic       win_pulse,
    output logic       cashout_pulse,
    output logic [9:0] cashout_amount,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SPIN, EVAL, PAYOUT} state_t;

    state_t          state_q, state_d;
    logic [9:0]      credits_q, credits_d;
    logic [1:0]      bet_q, bet_d;
    logic [2:0][1:0] pos_q, pos_d;
    logic [2:0]      stopped_q, stopped_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      ext_q, ext_d;
    logic [9:0]      payout_q, payout_d;
    logic            win_q, win_d;
    logic            cash_pulse_q, cash_pulse_d;
    logic [9:0]      cash_amt_q, cash_amt_d;
    logic [7:0]      lfsr_q;

    logic [2:0][8:0] thr;
    logic [8:0]      cnt_inc;
    logic [10:0]     sum;
    logic [4:0]      mult;

    assign thr[0]  = 9'(SPIN_MIN) + {5'd0, ext_q};
    assign thr[1]  = thr[0] + 9'(STAGGER);
    assign thr[2]  = thr[0] + 9'(2 * STAGGER);
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign sum     = {1'b0, credits_q} + {1'b0, payout_q};

    always_comb begin
        case (pos_q[0])
            2'd2:    mult = 5'd10;
            2'd3:    mult = 5'd20;
            default: mult = 5'd5;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        credits_d    = credits_q;
        bet_d        = bet_q;
        pos_d        = pos_q;
        stopped_d    = stopped_q;
        cnt_d        = cnt_q;
        ext_d        = ext_q;
        payout_d     = payout_q;
        win_d        = 1'b0;
        cash_pulse_d = 1'b0;
        cash_amt_d   = cash_amt_q;
        case (state_q)
            IDLE: begin
                // spin > cash > bet; losers in the same cycle are dropped
                if (btn_spin) begin
                    if (credits_q >= {8'd0, bet_q}) begin
                        credits_d = credits_q - {8'd0, bet_q};
                        state_d   = SPIN;
                        stopped_d = 3'b000;
                        cnt_d     = 8'd0;
                        ext_d     = RAND_EN ? lfsr_q[3:0] : 4'd0;
                    end
                end else if (btn_cash) begin
                    cash_amt_d   = credits_q;
                    credits_d    = 10'd0;
                    cash_pulse_d = 1'b1;
                end else if (btn_bet) begin
                    bet_d = (bet_q == 2'd3) ? 2'd1 : bet_q + 2'd1;
                end
            end
            SPIN: begin
                if (frame_tick) begin
                    for (int i = 0; i < 3; i++) begin
                        if ({1'b0, cnt_q} < thr[i]) pos_d[i] = pos_q[i] + 2'd1;
                        if (cnt_inc == thr[i]) stopped_d[i] = 1'b1;
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_inc == thr[2]) state_d = EVAL;
                end
            end
            EVAL: begin
                if (pos_q[0] == pos_q[1] && pos_q[1] == pos_q[2])
                    payout_d = {8'd0, bet_q} * {5'd0, mult};
                else if (pos_q[0] == pos_q[1])
                    payout_d = {8'd0, bet_q};
                else
                    payout_d = 10'd0;
                state_d = PAYOUT;
            end
            PAYOUT: begin
                credits_d = (sum > 11'd999) ? 10'd999 : sum[9:0];
                win_d     = (payout_q != 10'd0);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            credits_q    <= CREDIT_INIT;
            bet_q        <= 2'd1;
            pos_q        <= '0;
            stopped_q    <= 3'b111;
            cnt_q        <= 8'd0;
            ext_q        <= 4'd0;
            payout_q     <= 10'd0;
            win_q        <= 1'b0;
            cash_pulse_q <= 1'b0;
            cash_amt_q   <= 10'd0;
            lfsr_q       <= 8'h01;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            bet_q        <= bet_d;
            pos_q        <= pos_d;
            stopped_q    <= stopped_d;
            cnt_q        <= cnt_d;
            ext_q        <= ext_d;
            payout_q     <= payout_d;
            win_q        <= win_d;
            cash_pulse_q <= cash_pulse_d;
            cash_amt_q   <= cash_amt_d;
            lfsr_q       <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign reel_pos0      = pos_q[0];
    assign reel_pos1      = pos_q[1];
    assign reel_pos2      = pos_q[2];
    assign reel_stopped   = stopped_q;
    assign stop           = &stopped_q;
    assign credits        = credits_q;
    assign bet            = bet_q;
    assign payout         = payout_q;
    assign win_pulse      = win_q;
    assign cashout_pulse  = cash_pulse_q;
    assign cashout_amount = cash_amt_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: vector table, directed spin/reset/saturation sequences,
// and a random run against an arithmetic reference model (with and without LFSR).
module tb_slot_game_ctrl;
    localparam int SMIN = 32;
    localparam int STAG = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, btn_bet = 1'b0, btn_spin = 1'b0, btn_cash = 1'b0, frame_tick = 1'b0;
    logic s_rst = 1'b1, s_bet = 1'b0, s_spin = 1'b0, s_cash = 1'b0, s_ft = 1'b0;

    logic [1:0] m_p0, m_p1, m_p2, m_bet, r_p0, r_p1, r_p2, r_bet, s_p0, s_p1, s_p2, s_betq;
    logic [2:0] m_stp, r_stp, s_stp;
    logic       m_stop, m_win, m_cp, m_busy, r_stop, r_win, r_cp, r_busy, s_stop, s_win, s_cp, s_busy;
    logic [9:0] m_cred, m_pay, m_camt, r_cred, r_pay, r_camt, s_cred, s_pay, s_camt;

    slot_game_ctrl #(.RAND_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_bet(btn_bet), .btn_spin(btn_spin),
        .btn_cash(btn_cash), .reel_pos0(m_p0), .reel_pos1(m_p1), .reel_pos2(m_p2),
        .reel_stopped(m_stp), .stop(m_stop), .credits(m_cred), .bet(m_bet), .payout(m_pay),
        .win_pulse(m_win), .cashout_pulse(m_cp), .cashout_amount(m_camt), .busy(m_busy));

    slot_game_ctrl #(.RAND_EN(1'b1)) dut_r (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_bet(btn_bet), .btn_spin(btn_spin),
        .btn_cash(btn_cash), .reel_pos0(r_p0), .reel_pos1(r_p1), .reel_pos2(r_p2),
        .reel_stopped(r_stp), .stop(r_stop), .credits(r_cred), .bet(r_bet), .payout(r_pay),
        .win_pulse(r_win), .cashout_pulse(r_cp), .cashout_amount(r_camt), .busy(r_busy));

    slot_game_ctrl #(.RAND_EN(1'b0), .CREDIT_INIT(10'd990)) dut_s (
        .clk(clk), .rst(s_rst), .frame_tick(s_ft), .btn_bet(s_bet), .btn_spin(s_spin),
        .btn_cash(s_cash), .reel_pos0(s_p0), .reel_pos1(s_p1), .reel_pos2(s_p2),
        .reel_stopped(s_stp), .stop(s_stop), .credits(s_cred), .bet(s_betq), .payout(s_pay),
        .win_pulse(s_win), .cashout_pulse(s_cp), .cashout_amount(s_camt), .busy(s_busy));

    // phase: 0 idle, 1 spinning, 2 evaluating, 3 paying out
    typedef struct {
        int              phase, credits, bet, ticks, ext, payout, camt;
        logic [2:0][7:0] pos;
        logic [2:0]      stp;
        logic            win, cp;
        logic [7:0]      lfsr;
    } mdl_t;

    typedef struct {
        logic r, b, s, c, f;
        int   e_bet, e_cred, e_busy, e_cp, e_camt;
    } vec_t;

    mdl_t mm, mr;
    int   n_chk = 0, n_pass = 0;

    function automatic mdl_t mstep(mdl_t m, logic r, logic b, logic s, logic c, logic f, bit ren);
        mdl_t n = m;
        int   lim [3];
        n.win  = 1'b0;
        n.cp   = 1'b0;
        n.lfsr = {m.lfsr[6:0], ^(m.lfsr & 8'hB8)};
        if (r) begin
            n.phase = 0; n.credits = 100; n.bet = 1; n.ticks = 0; n.ext = 0;
            n.payout = 0; n.camt = 0; n.pos = '0; n.stp = 3'b111; n.lfsr = 8'h01;
            return n;
        end
        for (int i = 0; i < 3; i++) lim[i] = SMIN + m.ext + i * STAG;
        case (m.phase)
            0: if (s) begin
                   if (m.credits >= m.bet) begin
                       n.credits = m.credits - m.bet; n.phase = 1; n.ticks = 0;
                       n.ext = ren ? int'(m.lfsr % 16) : 0; n.stp = 3'b000;
                   end
               end else if (c) begin
                   n.camt = m.credits; n.credits = 0; n.cp = 1'b1;
               end else if (b) begin
                   n.bet = m.bet % 3 + 1;
               end
            1: if (f) begin
                   for (int i = 0; i < 3; i++)
                       if (m.ticks < lim[i]) n.pos[i] = 8'((m.pos[i] + 1) % 4);
                   n.ticks = m.ticks + 1;
                   for (int i = 0; i < 3; i++) n.stp[i] = (n.ticks >= lim[i]);
                   if (n.ticks == lim[2]) n.phase = 2;
               end
            2: begin
                   if (m.pos[0] == m.pos[1] && m.pos[1] == m.pos[2])
                       n.payout = m.bet * ((m.pos[0] == 3) ? 20 : (m.pos[0] == 2) ? 10 : 5);
                   else if (m.pos[0] == m.pos[1])
                       n.payout = m.bet;
                   else
                       n.payout = 0;
                   n.phase = 3;
               end
            default: begin
                   n.credits = (m.credits + m.payout > 999) ? 999 : m.credits + m.payout;
                   n.win = (m.payout != 0);
                   n.phase = 0;
               end
        endcase
        return n;
    endfunction

    function automatic logic [44:0] pack(mdl_t m);
        return {m.pos[0][1:0], m.pos[1][1:0], m.pos[2][1:0], m.stp, &m.stp, 10'(m.credits),
                2'(m.bet), 10'(m.payout), m.win, m.cp, 10'(m.camt), m.phase != 0};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        mm = mstep(mm, rst, btn_bet, btn_spin, btn_cash, frame_tick, 1'b0);
        mr = mstep(mr, rst, btn_bet, btn_spin, btn_cash, frame_tick, 1'b1);
        #1;
    endtask

    task automatic drive(logic r, logic b, logic s, logic c, logic f);
        rst = r; btn_bet = b; btn_spin = s; btn_cash = c; frame_tick = f;
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 100, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 100, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 100, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 100, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 100, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 99,  1, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 99,  1, 0, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 100, 0, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0,   0, 1, 100};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0,   0, 0, 100};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0,   0, 0, 100};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0,   0, 1, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0,   0, 1, 0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 100, 0, 0, 0};

        #1;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].f);
            if (i == 1) s_rst = 1'b0;
            tick();
            chk($sformatf("vec%0d_bet", i), 64'(m_bet), 64'(tbl[i].e_bet));
            chk($sformatf("vec%0d_credits", i), 64'(m_cred), 64'(tbl[i].e_cred));
            chk($sformatf("vec%0d_busy", i), 64'(m_busy), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d_cashpulse", i), 64'(m_cp), 64'(tbl[i].e_cp));
            chk($sformatf("vec%0d_cashamt", i), 64'(m_camt), 64'(tbl[i].e_camt));
        end
        chk("reset_reels", 64'({m_p0, m_p1, m_p2, m_stp, m_stop}), 64'(10'b000000_111_1));
        chk("reset_payout", 64'({m_pay, m_win}), 64'(0));

        // full spin from reset with bet 1, frame_tick every cycle
        drive(0, 0, 1, 0, 0); tick();
        chk("spin_credits", 64'(m_cred), 64'(99));
        chk("spin_stopped0", 64'(m_stp), 64'(0));
        drive(0, 0, 0, 0, 1);
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 31) chk("t31_reels", 64'({m_p0, m_p1, m_p2, m_stp}), 64'({2'd3, 2'd3, 2'd3, 3'b000}));
            if (k == 32) chk("t32_reels", 64'({m_p0, m_p1, m_p2, m_stp}), 64'({2'd0, 2'd0, 2'd0, 3'b001}));
            if (k == 33) chk("t33_reels", 64'({m_p0, m_p1, m_p2, m_stp}), 64'({2'd0, 2'd1, 2'd1, 3'b001}));
            if (k == 48) chk("t48_reels", 64'({m_p0, m_p1, m_p2, m_stp}), 64'({2'd0, 2'd0, 2'd0, 3'b011}));
            if (k == 63) chk("t63_stop", 64'({m_p2, m_stop, m_busy}), 64'({2'd3, 1'b0, 1'b1}));
        end
        chk("t64_reels", 64'({m_p0, m_p1, m_p2, m_stp, m_stop, m_busy}), 64'({6'd0, 3'b111, 1'b1, 1'b1}));
        tick();
        chk("eval_payout", 64'({m_pay, m_win, m_busy}), 64'({10'd5, 1'b0, 1'b1}));
        tick();
        chk("payout_credit", 64'({m_cred, m_win, m_busy}), 64'({10'd104, 1'b1, 1'b0}));
        tick();
        chk("win_one_cycle", 64'({m_cred, m_win}), 64'({10'd104, 1'b0}));

        // cash out 104, then spin with empty balance is ignored
        drive(0, 0, 0, 1, 0); tick();
        chk("cash104", 64'({m_camt, m_cred, m_cp}), 64'({10'd104, 10'd0, 1'b1}));
        drive(0, 0, 1, 0, 1); tick();
        chk("spin_broke", 64'({m_busy, m_cp, m_cred, m_stp}), 64'({1'b0, 1'b0, 10'd0, 3'b111}));

        // reset mid-spin
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 1);
        for (int k = 1; k <= 41; k++) tick();
        chk("midspin_reels", 64'({m_p0, m_p1, m_p2, m_stp, m_cred}), 64'({2'd0, 2'd1, 2'd1, 3'b001, 10'd99}));
        drive(1, 0, 0, 0, 1); tick();
        chk("midspin_reset", 64'({m_p0, m_p1, m_p2, m_stp, m_cred, m_busy}),
            64'({6'd0, 3'b111, 10'd100, 1'b0}));
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) tick();
        chk("post_reset_ticks", 64'({m_p0, m_p1, m_p2, m_stp, m_busy}), 64'({6'd0, 3'b111, 1'b0}));

        // saturation on the 990-credit instance
        drive(0, 0, 0, 0, 0);
        s_bet = 1'b1; tick(); tick(); s_bet = 1'b0;
        chk("sat_bet", 64'(s_betq), 64'(3));
        s_spin = 1'b1; tick(); s_spin = 1'b0;
        chk("sat_deduct", 64'(s_cred), 64'(987));
        s_ft = 1'b1;
        for (int k = 0; k < 64; k++) tick();
        s_ft = 1'b0;
        tick();
        chk("sat_payout", 64'(s_pay), 64'(15));
        tick();
        chk("sat_credit", 64'({s_cred, s_win}), 64'({10'd999, 1'b1}));

        // random run against the reference model
        for (int k = 0; k < 5000; k++) begin
            drive(($urandom_range(0, 699) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1);
            tick();
            chk("rand_fixed", 64'({m_p0, m_p1, m_p2, m_stp, m_stop, m_cred, m_bet, m_pay, m_win,
                                   m_cp, m_camt, m_busy}), 64'(pack(mm)));
            chk("rand_lfsr", 64'({r_p0, r_p1, r_p2, r_stp, r_stop, r_cred, r_bet, r_pay, r_win,
                                  r_cp, r_camt, r_busy}), 64'(pack(mr)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
